// File: rtl/ads1292_pkg.sv
// Shared constants and state encoding for the ADS1292 sample-to-float converter.
// Frame layout is {status[71:48], ch1[47:24], ch2[23:0]}; the header nibble is status[23:20].
package ads1292_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    NORM = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int unsigned FRAME_W  = 72;
  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned FLOAT_W  = 32;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;

  // A magnitude already normalized at bit 23 has value 1.m * 2^23.
  localparam int unsigned FP32_BIAS = 127;
  localparam int unsigned BASE_EXP  = FP32_BIAS + MANT_W;

  localparam int unsigned CH1_LSB = 24;
  localparam int unsigned CH2_LSB = 0;
  localparam int unsigned HDR_LSB = 68;
  localparam int unsigned HDR_W   = 4;

  localparam logic [HDR_W-1:0] HDR_OK = 4'b1100;

endpackage

// File: rtl/ads1292_data_to_float.sv
// Converts one 24-bit two's complement ADS1292 channel sample into an exact IEEE-754 single,
// normalizing iteratively one bit per cycle, with valid/ack handshakes on both sides.
module ads1292_data_to_float
  import ads1292_pkg::*;
#(
  parameter int CH_SEL    = 1,
  parameter int CHECK_HDR = 1
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic [FRAME_W-1:0] i_ADS1292_DATA_OUT,
  input  logic               i_ADS1292_DATA_VALID,
  output logic               o_ADS1292_DATA_ACK,
  output logic [FLOAT_W-1:0] o_ADS1292_FLOAT_DATA,
  output logic               o_ADS1292_FLOAT_DATA_VALID,
  input  logic               i_ADS1292_FLOAT_DATA_ACK,
  output logic               o_ADS1292_HDR_ERR
);

  localparam int unsigned CH_LSB = (CH_SEL == 0) ? CH1_LSB : CH2_LSB;

  state_t              state_q;
  state_t              state_d;
  logic [SAMPLE_W-1:0] sample_q;
  logic [HDR_W-1:0]    hdr_q;
  logic                sign_q;
  logic [SAMPLE_W-1:0] mag_q;
  logic [EXP_W-1:0]    exp_q;

  logic [SAMPLE_W-1:0] chan_sample;
  logic [SAMPLE_W-1:0] abs_sample;
  logic                hdr_bad;
  logic                norm_done;
  logic                unused_frame;

  assign chan_sample  = i_ADS1292_DATA_OUT[CH_LSB +: SAMPLE_W];
  // -8388608 negates to itself, which is exactly the 0x800000 magnitude wanted.
  assign abs_sample   = sample_q[SAMPLE_W-1] ? (~sample_q + 24'd1) : sample_q;
  assign hdr_bad      = (CHECK_HDR != 0) && (hdr_q != HDR_OK);
  assign norm_done    = (mag_q == '0) || mag_q[SAMPLE_W-1];
  assign unused_frame = ^i_ADS1292_DATA_OUT;

  always_ff @(posedge i_CLK) begin
    if (i_RST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_ADS1292_DATA_VALID) state_d = ABS;
      ABS:     state_d = hdr_bad ? IDLE : NORM;
      NORM:    if (norm_done) state_d = OUT;
      OUT:     if (i_ADS1292_FLOAT_DATA_ACK) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sample_q                   <= '0;
      hdr_q                      <= '0;
      sign_q                     <= 1'b0;
      mag_q                      <= '0;
      exp_q                      <= '0;
      o_ADS1292_DATA_ACK         <= 1'b0;
      o_ADS1292_HDR_ERR          <= 1'b0;
      o_ADS1292_FLOAT_DATA       <= '0;
      o_ADS1292_FLOAT_DATA_VALID <= 1'b0;
    end else begin
      o_ADS1292_DATA_ACK <= 1'b0;
      o_ADS1292_HDR_ERR  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_ADS1292_DATA_VALID) begin
            sample_q           <= chan_sample;
            hdr_q              <= i_ADS1292_DATA_OUT[HDR_LSB +: HDR_W];
            o_ADS1292_DATA_ACK <= 1'b1;
          end
        end
        ABS: begin
          sign_q            <= sample_q[SAMPLE_W-1];
          mag_q             <= abs_sample;
          exp_q             <= EXP_W'(BASE_EXP);
          o_ADS1292_HDR_ERR <= hdr_bad;
        end
        NORM: begin
          if (norm_done) begin
            // Zero has no implicit leading one, so it is emitted as +0 rather than packed.
            o_ADS1292_FLOAT_DATA       <= (mag_q == '0) ? '0 : {sign_q, exp_q, mag_q[MANT_W-1:0]};
            o_ADS1292_FLOAT_DATA_VALID <= 1'b1;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        OUT: begin
          if (i_ADS1292_FLOAT_DATA_ACK) o_ADS1292_FLOAT_DATA_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
